// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine
// N x N output-stationary systolic matrix multiply: C = A x B, or C += A x B.
// Operands are written into A/B storage while idle. A rising edge on start
// launches a run of 3N-2 cycles. Row i of A enters from the west and column j
// of B enters from the north, each skewed by its index, so PE(i,j) sees
// A[i][k] and B[k][j] together at t = i+j+k. Each PE keeps its C element.
module systolic_mm_engine #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int AW     = 2*DW + $clog2(N),
    parameter int SIGNED = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     accumulate,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [$clog2(N*N)-1:0]   wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(N*N)-1:0]   rd_addr,
    output logic [AW-1:0]            rd_data,
    output logic                     busy,
    output logic                     finish
);

    localparam int NN     = N * N;
    localparam int NP     = N * (N - 1);
    localparam int ADDR_W = $clog2(NN);
    localparam int CW     = $clog2(3*N - 2);
    localparam logic [CW-1:0] T_LAST = CW'(3*N - 3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_finish;
    logic            r_start_d;
    logic            r_armed;
    logic [CW-1:0]   r_t;

    // Operand storage, row-major i*N+j
    logic [DW-1:0]   r_a   [NN];
    logic [DW-1:0]   r_b   [NN];

    // Eastward operand registers: PE(i,j) -> PE(i,j+1), index i*(N-1)+j
    logic [DW-1:0]   r_ah  [NP];
    // Southward operand registers: PE(i,j) -> PE(i+1,j), index i*N+j
    logic [DW-1:0]   r_bv  [NP];

    // Output-stationary accumulators, one per PE (C element)
    logic [AW-1:0]   r_acc [NN];
    logic [AW-1:0]   r_rd;

    logic [DW-1:0]   w_west  [N];
    logic [DW-1:0]   w_north [N];
    logic [DW-1:0]   w_a_in  [NN];
    logic [DW-1:0]   w_b_in  [NN];
    logic            w_launch;
    logic            w_run;
    logic            w_wr_ok;
    logic            w_rd_ok;

    // Widen an operand to accumulator width, sign-extending when SIGNED.
    function automatic logic [AW-1:0] ext_op(input logic [DW-1:0] v);
        logic [AW-1:0] r;
        if (SIGNED != 0) begin
            r = AW'($signed(v));
        end else begin
            r = AW'(v);
        end
        return r;
    endfunction

    // Multiply-accumulate, wrapping modulo 2^AW (no saturation).
    function automatic logic [AW-1:0] mac(input logic [AW-1:0] acc,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [AW-1:0] p;
        p = ext_op(a) * ext_op(b);
        return acc + p;
    endfunction

    // r_armed requires start to be seen low after reset, so a start level
    // still high at reset release cannot launch a run.
    assign w_launch = start & ~r_start_d & r_armed & (r_state != S_RUN);
    assign w_run    = (r_state == S_RUN);
    assign w_wr_ok  = wr_en & ~r_busy & (int'(wr_addr) < NN);
    assign w_rd_ok  = (int'(rd_addr) < NN);

    assign rd_data  = r_rd;
    assign busy     = r_busy;
    assign finish   = r_finish;

    // Control FSM: launch detection, run counter, registered busy/finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
            r_t       <= '0;
            r_start_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_start_d <= start;
            if (!start) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_finish <= 1'b0;
                        r_t      <= '0;
                    end
                end
                S_RUN: begin
                    if (r_t == T_LAST) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                    end else begin
                        r_t <= r_t + CW'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_finish <= 1'b0;
                end
            endcase
        end
    end

    // Operand storage writes, accepted only while not computing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_wr_ok) begin
            if (wr_sel) begin
                r_b[wr_addr] <= wr_data;
            end else begin
                r_a[wr_addr] <= wr_data;
            end
        end
    end

    // Skewed edge feeds: row i gets A[i][t-i], column j gets B[t-j][j].
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_west[i]  = '0;
            w_north[i] = '0;
            if ((int'(r_t) >= i) && (int'(r_t) < i + N)) begin
                w_west[i]  = r_a[ADDR_W'(i*N + int'(r_t) - i)];
                w_north[i] = r_b[ADDR_W'((int'(r_t) - i)*N + i)];
            end
        end
    end

    // PE inputs: edge feeds on the first row/column, neighbour registers inside.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) begin
                    w_a_in[i*N+j] = w_west[i];
                end else begin
                    w_a_in[i*N+j] = r_ah[i*(N-1)+j-1];
                end
                if (i == 0) begin
                    w_b_in[i*N+j] = w_north[j];
                end else begin
                    w_b_in[i*N+j] = r_bv[(i-1)*N+j];
                end
            end
        end
    end

    // PE array: clear or keep C at launch, then MAC and forward operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NN; k++) begin
                r_acc[k] <= '0;
            end
            for (int k = 0; k < NP; k++) begin
                r_ah[k] <= '0;
                r_bv[k] <= '0;
            end
        end else if (w_launch) begin
            // Flush operand pipeline so nothing from a prior run leaks in.
            for (int k = 0; k < NP; k++) begin
                r_ah[k] <= '0;
                r_bv[k] <= '0;
            end
            if (!accumulate) begin
                for (int k = 0; k < NN; k++) begin
                    r_acc[k] <= '0;
                end
            end
        end else if (w_run) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_acc[i*N+j] <= mac(r_acc[i*N+j], w_a_in[i*N+j], w_b_in[i*N+j]);
                    if (j < N-1) begin
                        r_ah[i*(N-1)+j] <= w_a_in[i*N+j];
                    end
                    if (i < N-1) begin
                        r_bv[i*N+j] <= w_b_in[i*N+j];
                    end
                end
            end
        end
    end

    // Registered readback of C, zero for out-of-range addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd <= '0;
        end else if (w_rd_ok) begin
            r_rd <= r_acc[rd_addr];
        end else begin
            r_rd <= '0;
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine
// Directed bench for systolic_mm_engine (N=4, DW=8), with an unsigned and a
// signed instance sharing all inputs. A matrix-level model predicts busy,
// finish and readback; literal expectations pin the model.
module tb_systolic_mm_engine;

    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int AW      = 2*DW + $clog2(N);
    localparam int NN      = N * N;
    localparam int ADW     = $clog2(NN);
    localparam int RUN_CYC = 3*N - 2;

    logic           clk        = 1'b0;
    logic           rst        = 1'b0;
    logic           start      = 1'b0;
    logic           accumulate = 1'b0;
    logic           wr_en      = 1'b0;
    logic           wr_sel     = 1'b0;
    logic [ADW-1:0] wr_addr    = '0;
    logic [DW-1:0]  wr_data    = '0;
    logic [ADW-1:0] rd_addr    = '0;
    logic [AW-1:0]  rd_data;
    logic [AW-1:0]  rd_data_s;
    logic           busy;
    logic           finish;
    logic           busy_s;
    logic           finish_s;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: matrices, run progress, expected readback
    longint mA [NN];
    longint mB [NN];
    longint mC [NN];
    bit     m_busy = 1'b0;
    bit     m_fin  = 1'b0;
    bit     m_prev = 1'b1;
    bit     m_rdv  = 1'b1;
    int     m_cnt  = 0;
    longint m_rd   = 0;

    systolic_mm_engine #(.N(N), .DW(DW), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .finish(finish)
    );

    systolic_mm_engine #(.N(N), .DW(DW), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_s), .busy(busy_s), .finish(finish_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model step: a run is a whole-matrix product that becomes visible
    // RUN_CYC cycles after launch; readback is only predicted outside runs.
    task automatic model_step();
        bit     launch;
        longint s;
        if (!rst) begin
            for (int k = 0; k < NN; k++) begin
                mA[k] = 0;
                mB[k] = 0;
                mC[k] = 0;
            end
            m_busy = 1'b0;
            m_fin  = 1'b0;
            m_prev = 1'b1;
            m_cnt  = 0;
            m_rd   = 0;
            m_rdv  = 1'b1;
        end else begin
            m_rdv = !m_busy;
            m_rd  = mC[rd_addr];
            if (wr_en && !m_busy) begin
                if (wr_sel) mB[wr_addr] = longint'(wr_data);
                else        mA[wr_addr] = longint'(wr_data);
            end
            launch = start && !m_prev && !m_busy;
            m_prev = start;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_fin  = 1'b1;
                end
            end else if (launch) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        s = accumulate ? mC[i*N+j] : 0;
                        for (int k = 0; k < N; k++) begin
                            s += mA[i*N+k] * mB[k*N+j];
                        end
                        mC[i*N+j] = s % (longint'(1) << AW);
                    end
                end
                m_busy = 1'b1;
                m_fin  = 1'b0;
                m_cnt  = RUN_CYC;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    // Per-cycle comparison of the unsigned instance against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_busy", busy, longint'(m_busy));
                chk("cyc_finish", finish, longint'(m_fin));
                if (m_rdv) chk("cyc_rd_data", rd_data, m_rd);
            end
        end
    end

    task automatic wr(input bit sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = ADW'(addr);
        wr_data = DW'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int addr, output longint v, output longint vs);
        rd_addr = ADW'(addr);
        @(negedge clk);
        v  = longint'(rd_data);
        vs = longint'(rd_data_s);
    endtask

    task automatic launch(input bit acc);
        start      = 1'b1;
        accumulate = acc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!finish && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk(name, finish, 1);
    endtask

    initial begin
        longint v, vs;
        int cnt;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_finish", finish, 0);
        chk("reset_rd", rd_data, 0);

        // Identity x B, B[k] = k
        for (int k = 0; k < NN; k++) begin
            wr(0, k, (k % 5 == 0) ? 1 : 0);
            wr(1, k, k);
        end
        launch(0);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", cnt, 10);
        chk("t1_finish", finish, 1);
        for (int k = 0; k < NN; k++) begin
            rd(k, v, vs);
            chk("t1_c", v, k);
        end

        // All 255: unsigned 4*255*255, signed 4*(-1)*(-1)
        for (int k = 0; k < NN; k++) begin
            wr(0, k, 255);
            wr(1, k, 255);
        end
        launch(0);
        wait_done("t2_done");
        chk("t2_finish_s", finish_s, 1);
        chk("t2_busy_s", busy_s, 0);
        for (int k = 0; k < NN; k += 7) begin
            rd(k, v, vs);
            chk("t2_c_255", v, 260100);
            chk("t2_cs_m1", vs, 4);
        end
        // All 0x80: unsigned 4*128*128, signed 4*(-128)*(-128)
        for (int k = 0; k < NN; k++) begin
            wr(0, k, 128);
            wr(1, k, 128);
        end
        launch(0);
        wait_done("t2b_done");
        for (int k = 0; k < NN; k += 5) begin
            rd(k, v, vs);
            chk("t2_c_128", v, 65536);
            chk("t2_cs_m128", vs, 65536);
        end

        // Accumulate sequence with A = B = identity
        for (int k = 0; k < NN; k++) begin
            wr(0, k, (k % 5 == 0) ? 1 : 0);
            wr(1, k, (k % 5 == 0) ? 1 : 0);
        end
        launch(0);
        wait_done("t3_run1");
        rd(0, v, vs);  chk("t3_r1_diag", v, 1);
        rd(1, v, vs);  chk("t3_r1_off", v, 0);
        launch(1);
        wait_done("t3_run2");
        rd(0, v, vs);  chk("t3_r2_diag0", v, 2);
        rd(15, v, vs); chk("t3_r2_diag15", v, 2);
        rd(4, v, vs);  chk("t3_r2_off", v, 0);
        launch(0);
        wait_done("t3_run3");
        rd(10, v, vs); chk("t3_r3_diag", v, 1);

        // start held high for 200 cycles launches once
        start = 1'b1;
        accumulate = 1'b0;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("t4_single_run", cnt, 10);
        chk("t4_finish_held", finish, 1);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("t4_relaunch_busy", busy, 1);
        chk("t4_relaunch_finish", finish, 0);
        start = 1'b0;
        wait_done("t4_run2");

        // Write during run is ignored; write after finish lands
        for (int k = 0; k < NN; k++) wr(0, k, 0);
        wr(0, 0, 5);
        for (int j = 0; j < N; j++) wr(1, j, j + 1);
        launch(0);
        wr(0, 0, 99);
        wait_done("t5_run1");
        for (int j = 0; j < N; j++) begin
            rd(j, v, vs);
            chk("t5_old_a", v, 5 * (j + 1));
        end
        wr(0, 0, 99);
        launch(0);
        wait_done("t5_run2");
        for (int j = 0; j < N; j++) begin
            rd(j, v, vs);
            chk("t5_new_a", v, 99 * (j + 1));
        end
        rd(4, v, vs); chk("t5_row1", v, 0);

        // Reset mid-run with start held high
        start = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_finish", finish, 0);
        chk("t6_rst_rd", rd_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_launch", busy, 0);
        for (int k = 0; k < NN; k++) begin
            rd(k, v, vs);
            chk("t6_c_cleared", v, 0);
        end
        start = 1'b0;
        @(negedge clk);
        launch(0);
        chk("t6_toggle_launch", busy, 1);
        wait_done("t6_run");
        rd(0, v, vs);  chk("t6_ab_cleared0", v, 0);
        rd(5, v, vs);  chk("t6_ab_cleared5", v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised N×N output-stationary systolic matrix-multiply engine: computes C = A×B, or C += A×B in accumulate mode.
- Sits under the top-level integrated wrapper, between the UART command/data path and the result readback path.
- Exposes the start/finish handshake already used at top level.
- Generalises the fixed-size array: width, dimension and signedness are configurable; start is edge-triggered; accumulate mode is new.

Parameters:
- N, 4, array dimension (matrices are N×N), N>=2.
- DW, 8, operand width in bits.
- AW, 2*DW+$clog2(N), accumulator/result width.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, sign-extended before multiply.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  level input; a rising edge (0→1) launches a run.
- accumulate  in  1  sampled at the launch edge; 1 = keep C, 0 = clear C before the run.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = write A, 1 = write B.
- wr_addr  in  $clog2(N*N)  row-major address, i*N+j.
- wr_data  in  DW  operand value.
- rd_addr  in  $clog2(N*N)  row-major C address.
- rd_data  out  AW  registered C[rd_addr].
- busy  out  1  high while computing.
- finish  out  1  high from run completion until the next launch.

Behaviour:
- Reset (rst=0, asynchronous) clears all of the following to 0: state=IDLE, busy, finish, rd_data, all A/B storage, all accumulators, start edge register.
- Reset asserted mid-run aborts the run with the same clearing. After release, the engine needs a fresh 0→1 on start. If start is still high at release, it does NOT launch.
- Start detection: register start_d. launch = start & ~start_d & (state==IDLE or DONE). Start held high launches exactly one run.
- States:
  - IDLE: busy=0, finish=0.
  - RUN: busy=1, finish=0; counter t runs 0..3N-3.
  - DONE: busy=0, finish=1.
- Transitions:
  - IDLE→RUN on launch.
  - RUN→DONE on the edge where t==3N-3 completes.
  - DONE→RUN on launch.
  - No other exits except reset.
- Launch edge E0: t←0. If accumulate=0, all accumulators ←0 on the same edge. If accumulate=1, accumulators are kept.
- Feeding (skewed, combinational from counter and storage):
  - Row i west input = A[i][t-i] if 0<=t-i<N, else 0.
  - Column j north input = B[t-j][j] if 0<=t-j<N, else 0.
- PE(i,j) on each RUN edge:
  - acc += a_in*b_in.
  - a_out←a_in, b_out←b_in (registered; east and south neighbours use these).
  - Net effect: PE(i,j) consumes k-th operand pair at t=i+j+k.
- Latency: finish rises after edge E(3N-2), i.e. 3N-2 cycles after the launch edge (N=4 → 10 cycles). busy falls on the same edge.
- Arithmetic:
  - Products are DW×DW→2DW, extended to AW and summed modulo 2^AW (wrap, no saturation).
  - SIGNED=1 uses signed multiply and sign extension.
- Writes:
  - Accepted only when busy=0, on the edge with wr_en=1.
  - Writes while busy are ignored, and operands stay stable for the run.
  - Write and launch in the same cycle: the write lands; the run uses the new value.
- Reads:
  - rd_data ← C[rd_addr] on every edge (1-cycle latency), in any state.
  - During RUN the value is partial. It is final once finish=1.
- Out-of-range addresses (>=N*N, non-power-of-2 N): writes ignored, rd_data←0.

Test Plan:
- N=4, DW=8, SIGNED=0. A=identity, B[i][j]=i*4+j. Pulse start (accumulate=0) → finish exactly 10 cycles after launch; busy high those 10 cycles; read C[k]=k for k=0..15.
- All A,B = 255, unsigned → every C = 260100 (fits AW=18). Then SIGNED=1 with all -128 → every C = 65536.
- Accumulate run: first run (accumulate=0) with A=B=identity gives C=identity. Second launch with accumulate=1, same data → diagonal=2, off-diagonal=0. Third launch with accumulate=0 → diagonal back to 1.
- start driven 0→1 and held high for 200 cycles → exactly one run (busy high 10 cycles total); finish stays 1. Drop start, raise again → second run; finish falls on the launch edge.
- Assert rst=0 at t=5 of a run, start still high → busy=finish=0 immediately, all C read 0, A/B read back as 0. Release rst with start high → no launch until start toggles.
- During RUN, write A[0]=99 → ignored; the run's result uses the old A. After finish, write A[0]=99 and relaunch → C[0][j]=99*B[0][j] (with A otherwise zero).
